// File: rtl/ldm_stm_sequencer.sv
// Block-transfer (LDM/STM) sequencer: expands a register list into one address/register
// beat per set bit, then optionally strobes the updated base register.
module ldm_stm_sequencer #(
  parameter int STRIDE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] insn,
  input  logic [31:0] base,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [3:0]  out_reg,
  output logic [31:0] out_addr,
  output logic        out_load,
  output logic        out_last,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, XFER, WB} state_t;

  localparam logic [31:0] STEP = 32'(STRIDE);

  state_t      state;
  state_t      state_next;
  logic [15:0] list_q;
  logic [15:0] list_rest;
  logic [31:0] addr_q;
  logic [31:0] wb_data_q;
  logic        load_q;
  logic        wb_en_q;
  logic [4:0]  count;
  logic [31:0] span;
  logic [31:0] start_addr;
  logic        pre;
  logic        up;
  logic        unused_insn;

  assign pre         = insn[24];
  assign up          = insn[23];
  assign unused_insn = ^{insn[31:25], insn[22], insn[19:16]};

  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) begin
      count = count + 5'(insn[i]);
    end
  end

  assign span = STEP * {27'd0, count};

  // Descending modes still issue registers in ascending order, so they start at the bottom.
  always_comb begin
    start_addr = base;
    case ({pre, up})
      2'b01:   start_addr = base;
      2'b11:   start_addr = base + STEP;
      2'b00:   start_addr = base - span + STEP;
      default: start_addr = base - span;
    endcase
  end

  // Clearing the lowest set bit retires the register currently on out_reg.
  assign list_rest = list_q & (list_q - 16'd1);

  always_comb begin
    out_reg = '0;
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) out_reg = 4'(i);
    end
  end

  assign out_valid = (state == XFER);
  assign out_last  = (state == XFER) && (list_q != 16'd0) && (list_rest == 16'd0);
  assign out_addr  = addr_q;
  assign out_load  = load_q;
  assign wb_valid  = (state == WB) && wb_en_q;
  assign wb_data   = wb_data_q;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (count != 5'd0) ? XFER : WB;
      XFER: if (out_ready && out_last) state_next = WB;
      WB:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      list_q    <= '0;
      addr_q    <= '0;
      wb_data_q <= '0;
      load_q    <= 1'b0;
      wb_en_q   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        list_q    <= insn[15:0];
        addr_q    <= start_addr;
        wb_data_q <= up ? (base + span) : (base - span);
        load_q    <= insn[20];
        wb_en_q   <= insn[21];
      end else if (state == XFER && out_ready) begin
        list_q <= list_rest;
        addr_q <= addr_q + STEP;
      end
    end
  end

endmodule

// File: doc/ldm_stm_sequencer.md
LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
- REQ-001: Parameter STRIDE, default 4, bytes added per transferred register.
- REQ-002: clk  in  1  sole clock; all state updates on rising edge.
- REQ-003: rst_n  in  1  asynchronous, active-low reset.
- REQ-004: start  in  1  one-cycle request carrying a decoded block-transfer instruction.
- REQ-005: insn  in  32  instruction: [24]=P pre-index, [23]=U up, [21]=W writeback, [20]=L load, [15:0]=register list.
- REQ-006: base  in  32  Rn value from decode operand op0.
- REQ-007: out_ready  in  1  downstream accepts the current transfer beat.
- REQ-008: out_valid  out  1  transfer beat valid.
- REQ-009: out_reg  out  4  register index of current beat.
- REQ-010: out_addr  out  32  word address of current beat.
- REQ-011: out_load  out  1  captured L bit.
- REQ-012: out_last  out  1  current beat is the final transfer.
- REQ-013: wb_valid  out  1  one-cycle base-writeback strobe.
- REQ-014: wb_data  out  32  new base value.
- REQ-015: busy  out  1  stall request to decode; high whenever state is not IDLE.

Function
- REQ-016: States: IDLE, XFER, WB; no other states.
- REQ-017: IDLE + start: capture list, L, W, U, and compute n = popcount(list) and the start address; go to XFER if n>0, otherwise go to WB.
- REQ-018: start is ignored unless the state is IDLE.
- REQ-019: Start address (all math mod 2^32):
  - IA (P=0,U=1): base
  - IB (P=1,U=1): base+STRIDE
  - DA (P=0,U=0): base-STRIDE*n+STRIDE
  - DB (P=1,U=0): base-STRIDE*n
- REQ-020: Registers are issued in ascending index order regardless of U; the lowest register gets the lowest address.
- REQ-021: In XFER, out_valid=1, out_reg = lowest set bit of the remaining list, and out_addr = current address.
- REQ-022: A beat completes on out_valid & out_ready: clear that list bit and add STRIDE to the address. Beat outputs hold stable while out_ready=0.
- REQ-023: out_last=1 when exactly one list bit remains. Completion of the last beat moves the state to WB.
- REQ-024: In WB, wb_valid=1 for exactly one cycle iff W=1, then return to IDLE.
  - wb_data = U ? base+STRIDE*n : base-STRIDE*n, using the base captured at start.
- REQ-025: Empty list (n=0): no beats issued, and wb_data equals base.
- REQ-026: Latency: start to first beat is 1 cycle. With out_ready held high, a list of n registers occupies n XFER cycles plus 1 WB cycle. busy is high from the cycle after start through the WB cycle.
- REQ-027: List including r15: issued like any register; no special handling.
- REQ-028: Address wrap: 0xFFFFFFFC + STRIDE gives 0x00000000 with no flag.
- REQ-029: Outputs outside their valid cycle:
  - out_valid=0 and wb_valid=0.
  - out_reg, out_addr, out_load and wb_data are don't-care.

Reset
- REQ-030: rst_n low forces IDLE immediately, including mid-XFER or mid-WB. It clears the remaining list and aborts any pending beat or writeback.
- REQ-031: Output values while in reset: out_valid=0, out_last=0, wb_valid=0, busy=0, out_reg=0, out_addr=0, out_load=0, wb_data=0.
- REQ-032: The first start accepted after rst_n rises is processed normally.

Verification
- REQ-033: IA with writeback: base=0x1000, list=0x000B (r0,r1,r3), P=0, U=1, W=1, L=1, ready=1.
  - Beats: (r0,0x1000), (r1,0x1004), (r3,0x1008 with last).
  - Then wb_data=0x100C; busy high for 4 cycles.
- REQ-034: DB (push) without writeback: base=0x2000, list=0x4010 (r4,r14), P=1, U=0, W=0.
  - Beats: (r4,0x1FF8), (r14,0x1FFC with last).
  - wb_valid stays 0.
- REQ-035: Backpressure: IB, base=0x100, list=0x0006; hold out_ready=0 for 3 cycles on the first beat.
  - (r1,0x104) holds stable for those cycles; then (r2,0x108).
- REQ-036: Empty list with W=1, U=1, base=0x40.
  - No out_valid; wb_valid with wb_data=0x40 the cycle after start.
- REQ-037: Reset mid-operation: list=0xFFFF; assert rst_n=0 after the 5th beat.
  - All outputs go to reset values asynchronously.
  - A new start afterwards begins at its own r0.
- REQ-038: start asserted during XFER is ignored; the original sequence completes unchanged.
